xc_sha3_idx_seq: RTL and testbench
==================================

// Module: xc_sha3_idx_seq
//
// PURPOSE
//  Sequential SHA3 lane-address generator. One request sweeps all 25 (x,y)
//  lane positions of a Keccak state and streams one lane address per beat,
//  using the xy/x1/x2/x4/yx index functions.
//  It is a parametrised successor of the combinational sha3 indexer and sits
//  between the decode stage and the load/store address path, so a single
//  request drives a full theta/rho/pi/chi pass.
//
// PARAMETERS
//  ADDR_W     32  width of base and emitted addresses
//  LANE_SHIFT  3  log2 of bytes per lane (0..3); 3 gives 64-bit lanes
//
// PORTS
//  g_clk      in   1       clock; all state updates on the rising edge
//  g_reset    in   1       asynchronous reset, active-high
//  req_valid  in   1       sweep request valid
//  req_ready  out  1       block can accept a request
//  req_mode   in   3       0=xy 1=x1 2=x2 3=x4 4=yx; 5..7 are illegal
//  req_base   in   ADDR_W  state base address
//  req_err    out  1       1-cycle pulse: request with an illegal mode
//  abort      in   1       cancels the sweep in progress
//  out_valid  out  1       emitted beat valid
//  out_ready  in   1       consumer accepts the beat
//  out_addr   out  ADDR_W  req_base + (idx << LANE_SHIFT)
//  out_x      out  3       current x (0..4)
//  out_y      out  3       current y (0..4)
//  out_last   out  1       marks the final beat (x=4, y=4)
//
// BEHAVIOUR
//  - Reset values: state=IDLE, req_ready=1, out_valid=0, req_err=0,
//    out_last=0, out_addr/out_x/out_y=0.
//  - FSM states: IDLE and RUN.
//  - IDLE:
//    - req_ready=1.
//    - req_valid with a legal mode: capture mode and base, set x=y=0, go
//      to RUN.
//    - req_valid with an illegal mode: pulse req_err next cycle, stay IDLE.
//  - RUN:
//    - out_valid=1. The first beat appears the cycle after the request is
//      accepted.
//    - Beat handshake: out_valid & out_ready.
//    - Iteration order: x inner (0..4), y outer (0..4); exactly 25 beats.
//    - Stall (out_valid & !out_ready): out_addr, out_x, out_y and out_last
//      hold stable.
//    - Last beat accepted: go to IDLE, so req_ready=1 the next cycle.
//  - Index functions (mod 5 over the 3-bit coordinates):
//    - xy: idx = x + 5y
//    - x1/x2/x4: idx = ((x+k)%5) + 5y, with k = 1, 2 or 4
//    - yx: idx = y + 5*((2x+3y)%5)
//  - Width rules:
//    - idx is 5 bits (0..24) and is zero-extended before the shift.
//    - The addition wraps modulo 2^ADDR_W; no overflow flag.
//  - abort:
//    - Priority over a beat handshake in the same cycle.
//    - The next state is IDLE with out_valid=0.
//    - A beat presented in the abort cycle counts as not consumed.
//    - Abort while in IDLE: no effect.
//  - Mid-sweep reset: all outputs return to their reset values immediately
//    (asynchronous reset).
//  - out_addr is registered; no combinational path runs from req_* to out_*.
//
// CONFIGURATION
//  XC_SHA3_IDX_CHAIN_EN
//  - Defined:
//    - req_ready is also 1 during the last RUN beat while out_ready=1.
//    - A request accepted then starts the next sweep with zero bubble: its
//      beat 0 follows the last beat directly, and the state stays RUN.
//    - An illegal-mode request on that cycle pulses req_err and returns the
//      block to IDLE.
//  - Undefined: req_ready=1 only in IDLE, which gives at least a 1-cycle
//    gap between sweeps.
//
// TESTING
//  - Reset, then idle: req_ready=1, out_valid=0; abort in IDLE has no effect.
//  - xy, base 0x1000, LANE_SHIFT=3, out_ready=1:
//    - 25 beats 0x1000, 0x1008 ... 0x10C0.
//    - out_last set only on beat 25; req_ready high the next cycle.
//  - x4, base 0x1000: the beat with x=3, y=1 gives 0x1038 (idx 7).
//  - yx, base 0x1000:
//    - x=1, y=0 gives 0x1050 (idx 10).
//    - x=1, y=2 gives 0x1088 (idx 17).
//  - Random out_ready stalls: outputs stay stable while stalled; exactly 25
//    beats with no duplicates.
//  - Illegal mode, abort and chaining:
//    - req_mode=6 pulses req_err for 1 cycle; no beats are emitted.
//    - abort on beat 12 gives out_valid=0 the next cycle.
//    - CHAIN_EN: back-to-back requests produce 50 beats with no gap.

Source files
------------

// File: rtl/xc_sha3_idx_seq.sv
// Sequential SHA3 lane-address generator: one request streams all 25 lane addresses.
// Optional XC_SHA3_IDX_CHAIN_EN lets the next request start in the last beat's cycle, removing the gap between sweeps.
module xc_sha3_idx_seq #(
  parameter int ADDR_W     = 32,
  parameter int LANE_SHIFT = 3
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_mode,
  input  logic [ADDR_W-1:0] req_base,
  output logic              req_err,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [2:0]        out_x,
  output logic [2:0]        out_y,
  output logic              out_last
);

`ifdef XC_SHA3_IDX_CHAIN_EN
  localparam bit CHAIN_EN = 1'b1;
`else
  localparam bit CHAIN_EN = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [2:0]        x_q, x_d, y_q, y_d, mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic              last_q, last_d, err_q, err_d;
  logic [2:0]        nx, ny;
  logic              start, mode_legal;

  // Operands never exceed 24, so a short chain of conditional subtractions is enough.
  function automatic logic [4:0] mod5(input logic [4:0] v);
    logic [4:0] r;
    r = v;
    if (r >= 5'd20)      r = r - 5'd20;
    else if (r >= 5'd15) r = r - 5'd15;
    else if (r >= 5'd10) r = r - 5'd10;
    else if (r >= 5'd5)  r = r - 5'd5;
    return r;
  endfunction

  function automatic logic [4:0] lane_idx(input logic [2:0] mode, input logic [2:0] x,
                                          input logic [2:0] y);
    logic [4:0] x5, y5, row;
    x5  = {2'b00, x};
    y5  = {2'b00, y};
    row = y5 * 5'd5;
    case (mode)
      3'd1:    lane_idx = mod5(x5 + 5'd1) + row;
      3'd2:    lane_idx = mod5(x5 + 5'd2) + row;
      3'd3:    lane_idx = mod5(x5 + 5'd4) + row;
      3'd4:    lane_idx = y5 + mod5((x5 << 1) + y5 * 5'd3) * 5'd5;
      default: lane_idx = x5 + row;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] lane_addr(input logic [2:0] mode,
                                                  input logic [ADDR_W-1:0] base,
                                                  input logic [2:0] x, input logic [2:0] y);
    return base + (ADDR_W'(lane_idx(mode, x, y)) << LANE_SHIFT);
  endfunction

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    mode_d     = mode_q;
    base_d     = base_q;
    addr_d     = addr_q;
    last_d     = last_q;
    err_d      = 1'b0;
    start      = 1'b0;
    mode_legal = (req_mode <= 3'd4);
    nx         = (x_q == 3'd4) ? 3'd0 : x_q + 3'd1;
    ny         = (x_q == 3'd4) ? y_q + 3'd1 : y_q;
    req_ready  = (state_q == IDLE) ||
                 (CHAIN_EN && (state_q == RUN) && last_q && out_ready && !abort);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (mode_legal) start = 1'b1;
          else            err_d = 1'b1;
        end
      end
      RUN: begin
        // Abort wins over the handshake, so the presented beat is dropped.
        if (abort) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            last_d  = 1'b0;
            if (req_ready && req_valid) begin
              if (mode_legal) start = 1'b1;
              else            err_d = 1'b1;
            end
          end else begin
            x_d    = nx;
            y_d    = ny;
            addr_d = lane_addr(mode_q, base_q, nx, ny);
            last_d = (nx == 3'd4) && (ny == 3'd4);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = RUN;
      mode_d  = req_mode;
      base_d  = req_base;
      x_d     = 3'd0;
      y_d     = 3'd0;
      addr_d  = lane_addr(req_mode, req_base, 3'd0, 3'd0);
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q <= IDLE;
      x_q     <= 3'd0;
      y_q     <= 3'd0;
      mode_q  <= 3'd0;
      base_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == RUN);
  assign out_addr  = addr_q;
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_last  = last_q;
  assign req_err   = err_q;

endmodule

// File: tb/tb_xc_sha3_idx_seq.sv
// Scoreboard bench for xc_sha3_idx_seq: expected beats are queued at request time and popped by a monitor.
// The chaining scenario runs only when XC_SHA3_IDX_CHAIN_EN is defined.
module tb_xc_sha3_idx_seq;

  logic        g_clk = 1'b0;
  logic        g_reset, req_valid, abort, out_ready;
  logic [2:0]  req_mode;
  logic [31:0] req_base;
  logic        req_ready, req_err, out_valid, out_last;
  logic [31:0] out_addr;
  logic [2:0]  out_x, out_y;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  x;
    logic [2:0]  y;
    logic        last;
  } beat_t;

  beat_t       sb[$];
  int          checks = 0;
  int          failures = 0;
  int          popCount = 0;
  time         tFirst = 0;
  time         tLast = 0;
  logic [2:0]  curMode = 3'd0;
  logic        randReady = 1'b0;
  logic        stallPrev = 1'b0;
  logic [31:0] holdAddr;
  logic [2:0]  holdX, holdY;
  logic        holdLast;

  xc_sha3_idx_seq #(.ADDR_W(32), .LANE_SHIFT(3)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_base(req_base), .req_err(req_err), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_x(out_x), .out_y(out_y), .out_last(out_last)
  );

  always #5 g_clk = ~g_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference lane address, written with the % operator straight from the index formulas.
  function automatic logic [31:0] modelAddr(input int mode, input logic [31:0] base,
                                            input int x, input int y);
    int idx;
    case (mode)
      0:       idx = x + 5 * y;
      1:       idx = ((x + 1) % 5) + 5 * y;
      2:       idx = ((x + 2) % 5) + 5 * y;
      3:       idx = ((x + 4) % 5) + 5 * y;
      default: idx = y + 5 * ((2 * x + 3 * y) % 5);
    endcase
    return base + 32'(idx * 8);
  endfunction

  task automatic applyStimulus(input logic [2:0] mode, input logic [31:0] base, input int nBeats);
    int n = 0;
    beat_t b;
    while (!req_ready && n < 100) begin
      @(posedge g_clk);
      #1;
      n++;
    end
    checkOutput("req_ready_wait", {31'd0, req_ready}, 32'd1);
    curMode = mode;
    if (mode <= 3'd4) begin
      for (int i = 0; i < nBeats; i++) begin
        b.addr = modelAddr(int'(mode), base, i % 5, i / 5);
        b.x    = 3'(i % 5);
        b.y    = 3'(i / 5);
        b.last = (i == 24);
        sb.push_back(b);
      end
    end
    req_valid = 1'b1;
    req_mode  = mode;
    req_base  = base;
    @(posedge g_clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge g_clk);
      n++;
    end
    #1;
    checkOutput(name, sb.size(), 32'd0);
    sb.delete();
  endtask

  always @(posedge g_clk) begin
    if (randReady) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: stall stability, scoreboard pops on handshakes, and hand-computed spot values.
  always @(negedge g_clk) begin
    beat_t e;
    if (g_reset) begin
      stallPrev = 1'b0;
    end else begin
      if (stallPrev) begin
        checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("stall_addr", out_addr, holdAddr);
        checkOutput("stall_xy", {26'd0, out_x, out_y}, {26'd0, holdX, holdY});
        checkOutput("stall_last", {31'd0, out_last}, {31'd0, holdLast});
      end
      if (out_valid && out_ready && !abort) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_beat: got addr 0x%0h x=%0d y=%0d, expected no beat",
                   out_addr, out_x, out_y);
        end else begin
          e = sb.pop_front();
          checkOutput("beat_addr", out_addr, e.addr);
          checkOutput("beat_xy", {26'd0, out_x, out_y}, {26'd0, e.x, e.y});
          checkOutput("beat_last", {31'd0, out_last}, {31'd0, e.last});
          popCount++;
          if (popCount == 1) tFirst = $time;
          tLast = $time;
`ifndef XC_SHA3_IDX_CHAIN_EN
          if (e.last) checkOutput("ready_on_last", {31'd0, req_ready}, 32'd0);
`endif
        end
        if (curMode == 3'd0 && out_x == 3'd0 && out_y == 3'd0 && out_addr[31:12] == 20'h1)
          checkOutput("xy_first", out_addr, 32'h1000);
        if (curMode == 3'd0 && out_x == 3'd4 && out_y == 3'd4 && out_addr[31:12] == 20'h1)
          checkOutput("xy_final", out_addr, 32'h10C0);
        if (curMode == 3'd3 && out_x == 3'd3 && out_y == 3'd1)
          checkOutput("x4_x3y1", out_addr, 32'h1038);
        if (curMode == 3'd4 && out_x == 3'd1 && out_y == 3'd0 && out_addr[31:12] == 20'h1)
          checkOutput("yx_x1y0", out_addr, 32'h1050);
        if (curMode == 3'd4 && out_x == 3'd1 && out_y == 3'd2 && out_addr[31:12] == 20'h1)
          checkOutput("yx_x1y2", out_addr, 32'h1088);
      end
      stallPrev = out_valid && !out_ready && !abort;
      holdAddr  = out_addr;
      holdX     = out_x;
      holdY     = out_y;
      holdLast  = out_last;
    end
  end

  initial begin
    g_reset   = 1'b1;
    req_valid = 1'b0;
    req_mode  = 3'd0;
    req_base  = 32'd0;
    abort     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_err", {31'd0, req_err}, 32'd0);
    checkOutput("rst_last", {31'd0, out_last}, 32'd0);
    checkOutput("rst_addr", out_addr, 32'd0);
    checkOutput("rst_xy", {26'd0, out_x, out_y}, 32'd0);
    @(posedge g_clk);
    #1;
    g_reset = 1'b0;

    abort = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    checkOutput("idle_abort_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("idle_abort_valid", {31'd0, out_valid}, 32'd0);
    @(posedge g_clk);
    #1;
    abort = 1'b0;

    applyStimulus(3'd0, 32'h1000, 25);
    waitDrain("xy_drain");
    checkOutput("xy_ready_after", {31'd0, req_ready}, 32'd1);
    checkOutput("xy_valid_after", {31'd0, out_valid}, 32'd0);

    applyStimulus(3'd3, 32'h1000, 25);
    waitDrain("x4_drain");
    applyStimulus(3'd1, 32'h0000_0F00, 25);
    waitDrain("x1_drain");
    applyStimulus(3'd2, 32'hFFFF_FF80, 25);
    waitDrain("x2_wrap_drain");

    randReady = 1'b1;
    applyStimulus(3'd4, 32'h1000, 25);
    waitDrain("yx_stall_drain");
    randReady = 1'b0;
    @(posedge g_clk);
    #2;
    out_ready = 1'b1;
    checkOutput("yx_ready_after", {31'd0, req_ready}, 32'd1);

    applyStimulus(3'd6, 32'h2000, 25);
    @(negedge g_clk);
    checkOutput("illegal_err_pulse", {31'd0, req_err}, 32'd1);
    checkOutput("illegal_no_beat", {31'd0, out_valid}, 32'd0);
    @(negedge g_clk);
    checkOutput("illegal_err_clear", {31'd0, req_err}, 32'd0);
    checkOutput("illegal_still_idle", {31'd0, out_valid}, 32'd0);

    applyStimulus(3'd0, 32'h3000, 11);
    waitDrain("abort_pre_drain");
    abort = 1'b1;
    @(negedge g_clk);
    checkOutput("abort_beat12_xy", {26'd0, out_x, out_y}, {26'd0, 3'd1, 3'd2});
    @(posedge g_clk);
    #1;
    abort = 1'b0;
    @(negedge g_clk);
    checkOutput("abort_valid_low", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_ready", {31'd0, req_ready}, 32'd1);

    applyStimulus(3'd1, 32'h4000, 25);
    repeat (5) @(posedge g_clk);
    #3;
    g_reset = 1'b1;
    #1;
    sb.delete();
    checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_addr", out_addr, 32'd0);
    checkOutput("midrst_xy", {26'd0, out_x, out_y}, 32'd0);
    checkOutput("midrst_ready", {31'd0, req_ready}, 32'd1);
    @(posedge g_clk);
    #1;
    g_reset = 1'b0;

`ifdef XC_SHA3_IDX_CHAIN_EN
    begin
      int n = 0;
      popCount = 0;
      applyStimulus(3'd0, 32'h1000, 25);
      while (sb.size() != 1 && n < 200) begin
        @(posedge g_clk);
        n++;
      end
      #1;
      applyStimulus(3'd4, 32'h2000, 25);
      waitDrain("chain_drain");
      checkOutput("chain_beats", 32'(popCount), 32'd50);
      checkOutput("chain_span", 32'((tLast - tFirst) / 10), 32'd49);
      @(negedge g_clk);
      checkOutput("chain_idle", {31'd0, out_valid}, 32'd0);
    end
`endif

    repeat (3) @(posedge g_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
